// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Byte-addressed load/store front end for a word-addressed data
//             memory. It checks alignment and range, then performs
//             read-modify-write for sub-word stores and extends load data.
//  Options  : LSU_SUBWORD_EN enables byte/half access (word-only when undefined)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W   = 8,
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_wait_last = 4'(MEM_WAIT);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic                r_err;
    logic [ADDR_W-1:0]   r_widx;
    logic [31:0]         r_data;

    logic                w_accept;
    logic                w_req_err;
    logic                w_req_sub;
    logic                w_rd_last;
    logic [31:0]         w_mem_idx;
    logic [31:0]         w_rd_word;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_rd_last = (r_state == READ) && (r_cnt == c_wait_last);
    assign w_mem_idx = {{(32-ADDR_W){1'b0}}, r_widx};

`ifdef LSU_SUBWORD_EN
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merge;
    logic [31:0] w_load;

    assign w_req_sub = (req_size != 2'b10);

    always_comb begin
        w_req_err = (req_addr >> (ADDR_W + 2)) != 32'd0;
        case (req_size)
            2'b00:   ;
            2'b01:   if (req_addr[0]) w_req_err = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) w_req_err = 1'b1;
            default: w_req_err = 1'b1;
        endcase
    end

    // Little-endian lanes; the store data sits right-justified in r_data.
    always_comb begin
        w_byte  = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half  = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_merge = mem_rdata;
        w_load  = mem_rdata;
        case (r_size)
            2'b00: begin
                w_merge[{r_lane, 3'b000} +: 8] = r_data[7:0];
                w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            end
            2'b01: begin
                w_merge[{r_lane[1], 4'b0000} +: 16] = r_data[15:0];
                w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
            end
            default: ;
        endcase
    end

    assign w_rd_word = r_write ? w_merge : w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_size     <= req_size;
            r_lane     <= req_addr[1:0];
            r_unsigned <= req_unsigned;
        end
    end
`else
    logic w_unused_ok;

    assign w_unused_ok = req_unsigned;
    assign w_req_sub   = 1'b0;
    assign w_rd_word   = mem_rdata;

    always_comb begin
        w_req_err = (req_addr >> (ADDR_W + 2)) != 32'd0;
        if ((req_size != 2'b10) || (req_addr[1:0] != 2'b00)) w_req_err = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        mem_addr  = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err)                  w_next = RESP;
                    else if (!req_write || w_req_sub) w_next = READ;
                    else                            w_next = WRITE;
                end
            end
            READ: begin
                mem_read = 1'b1;
                mem_addr = w_mem_idx;
                if (w_rd_last) w_next = r_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = w_mem_idx;
                mem_wdata = r_data;
                w_next    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = (r_write || r_err) ? 32'd0 : r_data;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_data holds the store word until the read returns, then the load
    // result or the merged write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_widx  <= '0;
            r_data  <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= 4'd0;
            r_write <= req_write;
            r_err   <= w_req_err;
            r_widx  <= req_addr[ADDR_W+1:2];
            r_data  <= req_wdata;
        end else if (r_state == READ) begin
            if (w_rd_last) r_data <= w_rd_word;
            else           r_cnt  <= r_cnt + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Directed and random requests against a behavioural memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int P_WAIT  = 2;
    localparam int P_BOUND = 40;
`ifdef LSU_SUBWORD_EN
    localparam bit P_SUBWORD = 1'b1;
`else
    localparam bit P_SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    bit          mem_loaded = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    load_store_unit #(.ADDR_W(8), .MEM_WAIT(P_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'h8C12_3456 : ((32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_1F0E);
    endfunction

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One request end to end; the expected outcome comes from the byte-level rules.
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        exp_err, got_err;
        logic [31:0] exp_rd, exp_word, mask, field, got_rd, wr_data;
        int          bits, sh, exp_lat, exp_nrd, exp_nwr, exp_wcyc;
        int          lat, nrd, nwr, wcyc, nviol;

        n_txn++;
        exp_err = ((addr >> 10) != 32'd0) || (sz == 2'b11) ||
                  (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00) ||
                  (!P_SUBWORD && sz != 2'b10);
        bits     = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        sh       = 8 * int'(addr[1:0]);
        mask     = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        exp_word = ref_mem[addr[9:2]];
        exp_rd   = 32'd0;
        exp_lat  = 1;
        exp_nrd  = 0;
        exp_nwr  = 0;
        exp_wcyc = 0;
        if (!exp_err && !wr) begin
            field = (exp_word >> sh) & mask;
            if (!uns && bits < 32 && field[bits-1]) field = field | ~mask;
            exp_rd  = field;
            exp_lat = 2 + P_WAIT;
            exp_nrd = P_WAIT + 1;
        end else if (!exp_err) begin
            exp_word = (exp_word & ~(mask << sh)) | ((wd & mask) << sh);
            exp_nwr  = 1;
            if (bits == 32) begin
                exp_lat  = 2;
                exp_wcyc = 1;
            end else begin
                exp_lat  = 3 + P_WAIT;
                exp_nrd  = P_WAIT + 1;
                exp_wcyc = P_WAIT + 2;
            end
            ref_mem[addr[9:2]] = exp_word;
        end

        @(negedge clk);
        check($sformatf("ready[%0d]", n_txn), {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;

        lat = 0; nrd = 0; nwr = 0; wcyc = 0; nviol = 0;
        got_err = 1'b0; got_rd = 32'd0; wr_data = 32'd0;
        for (int c = 1; c <= P_BOUND && lat == 0; c++) begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wcyc    = c;
                wr_data = mem_wdata;
            end
            if (mem_read && mem_write) nviol++;
            if (!mem_write && mem_wdata !== 32'd0) nviol++;
            if ((mem_read || mem_write) && mem_addr !== {22'd0, addr[9:2]}) nviol++;
            if (rsp_valid) begin
                lat     = c;
                got_err = rsp_err;
                got_rd  = rsp_rdata;
            end else begin
                @(posedge clk);
                #1;
            end
        end

        check($sformatf("latency[%0d]", n_txn), 32'(lat), 32'(exp_lat));
        check($sformatf("err[%0d]", n_txn), {31'd0, got_err}, {31'd0, exp_err});
        check($sformatf("rdata[%0d]", n_txn), got_rd, exp_rd);
        check($sformatf("reads[%0d]", n_txn), 32'(nrd), 32'(exp_nrd));
        check($sformatf("writes[%0d]", n_txn), 32'(nwr), 32'(exp_nwr));
        check($sformatf("wcycle[%0d]", n_txn), 32'(wcyc), 32'(exp_wcyc));
        check($sformatf("protocol[%0d]", n_txn), 32'(nviol), 32'd0);
        if (exp_nwr != 0) check($sformatf("wdata[%0d]", n_txn), wr_data, exp_word);

        if (lat == 0) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
        end else begin
            @(posedge clk);
            #1;
        end
        check($sformatf("mem[%0d]", n_txn), mem[addr[9:2]], ref_mem[addr[9:2]]);
    endtask

    initial begin
        int          nrsp;
        logic [1:0]  sz;
        logic [31:0] addr;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        #2;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_memctl", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
        do_txn(1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'd0);
        do_txn(1'b0, 2'b01, 1'b1, 32'h0000_000C, 32'd0);
        do_txn(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_00AB);
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'd0);
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0);
        do_txn(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'd0);
        do_txn(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_8001);
        do_txn(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hDEAD_BEEF);
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'd0);
        do_txn(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0);

        for (int k = 0; k < 120; k++) begin
            sz   = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(10, 31));
            do_txn(1'($urandom), sz, 1'($urandom), addr, $urandom);
        end

        // Asynchronous reset in the middle of a load's READ phase.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0000_000C;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_read", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_read", {31'd0, mem_read}, 32'd0);
        check("async_ready", {31'd0, req_ready}, 32'd1);
        check("async_rsp", {31'd0, rsp_valid}, 32'd0);
        check("async_maddr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) nrsp++;
        end
        check("no_rsp_after_rst", 32'(nrsp), 32'd0);

        // Asynchronous reset during a word store's write cycle: nothing is written.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 32'h0000_0020; req_wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pre_rst_write", {31'd0, mem_write}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_write", {31'd0, mem_write}, 32'd0);
        check("async_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_partial_write", mem[8], ref_mem[8]);

        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
